// File: rtl/unsigned7x7_pp_reducer_if.sv
// Handshake and data bundle for the 7x7 unsigned radix-4 partial-product reducer.
// The producer (master) drives the partial products and the consumer-side ready;
// the reducer (slave) returns ready, the product and the delivery count.
interface unsigned7x7_pp_reducer_if;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] pp00;
  logic [12:0] pp01;
  logic [11:0] pp02;
  logic [9:0]  pp03;
  logic        out_valid;
  logic        out_ready;
  logic [13:0] prod;
  logic [15:0] op_count;

  modport master (
    output in_valid, pp00, pp01, pp02, pp03, out_ready,
    input  in_ready, out_valid, prod, op_count
  );

  modport slave (
    input  in_valid, pp00, pp01, pp02, pp03, out_ready,
    output in_ready, out_valid, prod, op_count
  );
endinterface

// File: rtl/unsigned7x7_pp_reducer.sv
// Two-stage reducer for four Booth radix-4 partial products of a 7x7 unsigned
// multiply. Stage 1 compresses the aligned operands 4:2 into a sum/carry pair,
// stage 2 performs the carry-propagate add. Everything is modulo 2^14, which is
// where the upstream sign-extension constants cancel. Valid/ready elastic
// pipeline with a delivered-product counter.
module unsigned7x7_pp_reducer (
  input  logic                         clk,
  input  logic                         rst_n,
  unsigned7x7_pp_reducer_if.slave      bus
);

  logic        v1_q, v1_d;
  logic        v2_q, v2_d;
  logic [13:0] sum_q, sum_d;
  logic [13:0] carry_q, carry_d;
  logic [13:0] prod_q, prod_d;
  logic [15:0] op_count_q, op_count_d;

  logic        s2_load;
  logic        s1_load;
  logic        accept;
  logic        deliver;

  logic [13:0] op_a, op_b, op_c, op_d;
  logic [13:0] csa0_s, csa0_c;
  logic [13:0] csa1_s, csa1_c;

  // Stage enables: S2 advances when empty or drained; S1 when empty or S2 advances.
  always_comb begin
    s2_load = ~v2_q | bus.out_ready;
    s1_load = ~v1_q | s2_load;
    accept  = bus.in_valid & s1_load;
    deliver = v2_q & bus.out_ready;
  end

  // Operand alignment and 4:2 compression built from two 3:2 carry-save rows.
  always_comb begin
    op_a   = {2'b00, bus.pp00};
    op_b   = {1'b0, bus.pp01};
    op_c   = {bus.pp02, 2'b00};
    op_d   = {bus.pp03, 4'b0000};
    csa0_s = op_a ^ op_b ^ op_c;
    csa0_c = ((op_a & op_b) | (op_a & op_c) | (op_b & op_c)) << 1;
    csa1_s = csa0_s ^ csa0_c ^ op_d;
    csa1_c = ((csa0_s & csa0_c) | (csa0_s & op_d) | (csa0_c & op_d)) << 1;
  end

  // Next-state for valid bits, data registers and the delivery counter.
  always_comb begin
    v1_d       = v1_q;
    v2_d       = v2_q;
    sum_d      = sum_q;
    carry_d    = carry_q;
    prod_d     = prod_q;
    op_count_d = op_count_q;
    if (s1_load) begin
      v1_d = bus.in_valid;
    end
    if (accept) begin
      sum_d   = csa1_s;
      carry_d = csa1_c;
    end
    if (s2_load) begin
      v2_d = v1_q;
    end
    // prod only moves when a real set advances, so it holds while stalled.
    if (s2_load && v1_q) begin
      prod_d = sum_q + carry_q;
    end
    if (deliver) begin
      op_count_d = op_count_q + 16'd1;
    end
  end

  // Pipeline state registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q       <= 1'b0;
      v2_q       <= 1'b0;
      sum_q      <= '0;
      carry_q    <= '0;
      prod_q     <= '0;
      op_count_q <= '0;
    end else begin
      v1_q       <= v1_d;
      v2_q       <= v2_d;
      sum_q      <= sum_d;
      carry_q    <= carry_d;
      prod_q     <= prod_d;
      op_count_q <= op_count_d;
    end
  end

  assign bus.in_ready  = s1_load;
  assign bus.out_valid = v2_q;
  assign bus.prod      = prod_q;
  assign bus.op_count  = op_count_q;

endmodule

// File: tb/tb_unsigned7x7_pp_reducer.sv
// Bench for the 7x7 partial-product reducer: a local Booth radix-4 encoder with
// sign-extension constants builds the partial products from (a,b); expected
// products are a*b, taken from hand-written tables or a direct multiply model.
module tb_unsigned7x7_pp_reducer;

  typedef struct {
    logic [11:0] pp00;
    logic [12:0] pp01;
    logic [11:0] pp02;
    logic [9:0]  pp03;
  } pp_t;

  typedef struct {
    logic [6:0]  a;
    logic [6:0]  b;
    logic [13:0] expv;
  } vec_t;

  typedef struct {
    logic [6:0] a;
    logic [6:0] b;
  } ab_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   accepted;
  int   delivered;

  ab_t         pend_q[$];
  logic [13:0] exp_q[$];
  vec_t        vecs[11];

  unsigned7x7_pp_reducer_if bus ();

  unsigned7x7_pp_reducer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, expv, expv);
    end
  endfunction

  // Radix-4 Booth encoding of unsigned b (b7 = 0), one's-complement negation with
  // separate neg bits, and the ~s,s,s / 1,~s sign-extension pattern mod 2^14.
  function automatic pp_t booth_pp(input logic [6:0] a, input logic [6:0] b);
    pp_t        p;
    logic [8:0] bx;
    logic [8:0] x [4];
    logic       neg [4];
    logic [8:0] mv;
    int         d;
    int         m;
    bx = {1'b0, b, 1'b0};
    for (int i = 0; i < 4; i++) begin
      d      = -2 * int'(bx[2*i+2]) + int'(bx[2*i+1]) + int'(bx[2*i]);
      neg[i] = (d < 0);
      m      = (d < 0 ? -d : d) * int'(a);
      mv     = 9'(m);
      x[i]   = neg[i] ? ~mv : mv;
    end
    p.pp00 = {~x[0][8], x[0][8], x[0][8], x[0]};
    p.pp01 = {1'b1, ~x[1][8], x[1], 1'b0, neg[0]};
    p.pp02 = {~x[2][8], x[2], 1'b0, neg[1]};
    p.pp03 = {x[3][7:0], 1'b0, neg[2]};
    return p;
  endfunction

  function automatic logic [13:0] mul7(input logic [6:0] a, input logic [6:0] b);
    return 14'(int'(a) * int'(b));
  endfunction

  task automatic drive_pp(input pp_t p);
    bus.pp00 = p.pp00;
    bus.pp01 = p.pp01;
    bus.pp02 = p.pp02;
    bus.pp03 = p.pp03;
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    pend_q.delete();
    exp_q.delete();
    accepted  = 0;
    delivered = 0;
    repeat (2) @(negedge clk);
    check("ready_in_reset", 32'(bus.in_ready), 32'd1);
    rst_n = 1'b1;
    #1;
    check("ready_after_reset", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
  endtask

  // One clock: offer the head of pend_q, check any presented product against
  // the scoreboard, then account for accept/deliver across the rising edge.
  task automatic step(input logic ordy);
    logic acc;
    logic dlv;
    bus.out_ready = ordy;
    if (pend_q.size() > 0) begin
      bus.in_valid = 1'b1;
      drive_pp(booth_pp(pend_q[0].a, pend_q[0].b));
    end else begin
      bus.in_valid = 1'b0;
    end
    #1;
    acc = bus.in_valid & bus.in_ready;
    dlv = 1'b0;
    if (bus.out_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_out_valid", 32'(bus.out_valid), 32'd0);
      end else begin
        check("prod", 32'(bus.prod), 32'(exp_q[0]));
        dlv = ordy;
      end
    end
    @(posedge clk);
    if (dlv) begin
      void'(exp_q.pop_front());
      delivered++;
    end
    if (acc) begin
      exp_q.push_back(mul7(pend_q[0].a, pend_q[0].b));
      void'(pend_q.pop_front());
      accepted++;
    end
    @(negedge clk);
  endtask

  // Single set with out_ready high: measure accept-to-out_valid latency.
  task automatic run_vec(input string name, input pp_t p, input logic [13:0] expv);
    int lat;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    drive_pp(p);
    #1;
    check({name, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat = 0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        lat = c;
        break;
      end
    end
    check({name, "_latency"}, 32'(lat), 32'd2);
    check({name, "_prod"}, 32'(bus.prod), 32'(expv));
  endtask

  initial begin
    pp_t p;
    total = 0;
    bad   = 0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.pp00 = '0;
    bus.pp01 = '0;
    bus.pp02 = '0;
    bus.pp03 = '0;

    vecs[0]  = '{a: 7'd127, b: 7'd127, expv: 14'd16129};
    vecs[1]  = '{a: 7'd0,   b: 7'd85,  expv: 14'd0};
    vecs[2]  = '{a: 7'd127, b: 7'd1,   expv: 14'd127};
    vecs[3]  = '{a: 7'd1,   b: 7'd1,   expv: 14'd1};
    vecs[4]  = '{a: 7'd2,   b: 7'd3,   expv: 14'd6};
    vecs[5]  = '{a: 7'd100, b: 7'd100, expv: 14'd10000};
    vecs[6]  = '{a: 7'd85,  b: 7'd85,  expv: 14'd7225};
    vecs[7]  = '{a: 7'd127, b: 7'd64,  expv: 14'd8128};
    vecs[8]  = '{a: 7'd64,  b: 7'd127, expv: 14'd8128};
    vecs[9]  = '{a: 7'd42,  b: 7'd3,   expv: 14'd126};
    vecs[10] = '{a: 7'd5,   b: 7'd126, expv: 14'd630};

    // Reset state.
    do_reset();
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_prod", 32'(bus.prod), 32'd0);
    check("rst_op_count", 32'(bus.op_count), 32'd0);

    // Raw partial products: only pp00 = 1.
    p.pp00 = 12'h001;
    p.pp01 = 13'h0;
    p.pp02 = 12'h0;
    p.pp03 = 10'h0;
    run_vec("direct", p, 14'd1);

    // Table of Booth-encoded products.
    for (int i = 0; i < 11; i++) begin
      run_vec($sformatf("vec%0d", i), booth_pp(vecs[i].a, vecs[i].b), vecs[i].expv);
    end

    // Back-to-back stream of 64 random operand pairs.
    do_reset();
    for (int i = 0; i < 64; i++) begin
      pend_q.push_back('{a: 7'($urandom_range(0, 127)), b: 7'($urandom_range(0, 127))});
    end
    for (int i = 0; i < 66; i++) step(1'b1);
    check("stream_delivered", 32'(delivered), 32'd64);
    check("stream_op_count", 32'(bus.op_count), 32'd64);

    // Backpressure: 3 sets offered, out_ready low for 5 cycles.
    do_reset();
    pend_q.push_back('{a: 7'd11, b: 7'd13});
    pend_q.push_back('{a: 7'd100, b: 7'd99});
    pend_q.push_back('{a: 7'd127, b: 7'd126});
    for (int i = 0; i < 5; i++) step(1'b0);
    check("bp_accepted", 32'(accepted), 32'd2);
    bus.out_ready = 1'b0;
    #1;
    check("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
    check("bp_prod_held", 32'(bus.prod), 32'd143);
    step(1'b1);
    check("bp_third_accepted", 32'(accepted), 32'd3);
    for (int i = 0; i < 3; i++) step(1'b1);
    check("bp_delivered", 32'(delivered), 32'd3);
    check("bp_op_count", 32'(bus.op_count), 32'd3);

    // Asynchronous reset with the pipeline full.
    do_reset();
    pend_q.push_back('{a: 7'd3, b: 7'd5});
    pend_q.push_back('{a: 7'd7, b: 7'd9});
    pend_q.push_back('{a: 7'd77, b: 7'd66});
    for (int i = 0; i < 5; i++) step(1'b1);
    pend_q.push_back('{a: 7'd120, b: 7'd121});
    pend_q.push_back('{a: 7'd33, b: 7'd44});
    for (int i = 0; i < 3; i++) step(1'b0);
    check("ar_pre_out_valid", 32'(bus.out_valid), 32'd1);
    check("ar_pre_op_count", 32'(bus.op_count), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_out_valid", 32'(bus.out_valid), 32'd0);
    check("ar_prod", 32'(bus.prod), 32'd0);
    check("ar_op_count", 32'(bus.op_count), 32'd0);
    check("ar_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    pend_q.delete();
    exp_q.delete();
    for (int i = 0; i < 4; i++) step(1'b1);
    check("ar_no_stale", 32'(bus.out_valid), 32'd0);
    run_vec("ar_new", booth_pp(7'd9, 7'd9), 14'd81);

    // op_count wrap after 65535 deliveries.
    do_reset();
    for (int i = 0; i < 65537; i++) begin
      if (i < 65535) pend_q.push_back('{a: 7'(i % 128), b: 7'((i / 128) % 128)});
      step(1'b1);
    end
    check("wrap_pre", 32'(bus.op_count), 32'hFFFF);
    pend_q.push_back('{a: 7'd127, b: 7'd127});
    for (int i = 0; i < 3; i++) step(1'b1);
    check("wrap_delivered", 32'(delivered), 32'd65536);
    check("wrap_op_count", 32'(bus.op_count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/unsigned7x7_pp_reducer.md
UNSIGNED7X7_PP_REDUCER -- requirements
Module: unsigned7x7_pp_reducer

Interface
REQ-001 SHALL have parameter: none; all widths fixed for the 7x7 unsigned radix-4 path.
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1, partial-product set present on pp00..pp03.
REQ-005 SHALL have port in_ready, output, 1, block accepts the set this cycle.
REQ-006 SHALL have port pp00, input, 12, sign-extended partial product 0.
REQ-007 SHALL have port pp01, input, 13, partial product 1 with negation bits of pp00 in bits [1:0].
REQ-008 SHALL have port pp02, input, 12, partial product 2 with negation bits of pp01 in bits [1:0].
REQ-009 SHALL have port pp03, input, 10, partial product 3 with negation bits of pp02 in bits [1:0].
REQ-010 SHALL have port out_valid, output, 1, product on prod is valid.
REQ-011 SHALL have port out_ready, input, 1, consumer takes prod this cycle.
REQ-012 SHALL have port prod, output, 14, unsigned 7x7 product.
REQ-013 SHALL have port op_count, output, 16, number of products delivered since reset.

Function
REQ-014 SHALL align operands as: pp00 at bit 0, pp01 at bit 0, pp02 at bit 2, pp03 at bit 4, each zero-extended to 14 bits after shifting.
REQ-015 SHALL compute prod = (pp00 + pp01 + (pp02<<2) + (pp03<<4)) mod 2^14; bits above 13 discarded (sign-extension constants cancel there).
REQ-016 SHALL be a two-stage pipeline: S1 registers a carry-save pair (sum14, carry14) from a 4:2 compression of the aligned operands; S2 registers the carry-propagate result sum14+carry14 mod 2^14 into prod.
REQ-017 SHALL have latency exactly 2 cycles from accepted input (in_valid & in_ready) to out_valid with no backpressure.
REQ-018 SHALL sustain one accepted set per cycle while out_ready stays high.
REQ-019 S2 SHALL load when S2 empty or out_ready=1; S1 SHALL load when S1 empty or S2 loads (per-stage valid bits v1, v2).
REQ-020 in_ready SHALL equal (~v1) | S2-load condition; combinational from out_ready, no path from in_valid.
REQ-021 out_valid SHALL equal v2; prod SHALL hold stable while out_valid=1 and out_ready=0.
REQ-022 A stage whose input is not valid while loading SHALL clear its valid bit; data registers MAY keep stale values.
REQ-023 Simultaneous accept and deliver with pipeline full SHALL move all stages forward with no bubble and no loss.
REQ-024 op_count SHALL increment by 1 on each cycle with out_valid & out_ready, wrapping 0xFFFF -> 0x0000.
REQ-025 in_valid high while in_ready low SHALL not be consumed; upstream holds data.

Reset
REQ-026 rst_n low SHALL immediately clear v1, v2, prod, sum/carry registers and op_count to 0, independent of clk.
REQ-027 Reset mid-operation SHALL discard in-flight sets; first out_valid after release requires a new accepted input plus 2 cycles.
REQ-028 in_ready SHALL be 1 during and immediately after reset (pipeline empty).

Verification
REQ-029 Direct vector: pp00=12'h001, pp01=13'h0, pp02=12'h0, pp03=10'h0, out_ready=1 -> prod=14'd1, out_valid exactly 2 cycles after accept.
REQ-030 End-to-end with upstream Booth encoder and sign extension, a=127, b=127 -> prod=14'h3F01 (16129); a=0, b=85 -> 0; a=127, b=1 -> 127.
REQ-031 Back-to-back 64 random (a,b) with out_ready=1 -> one result per cycle, in order, each equal a*b, op_count=64.
REQ-032 Hold out_ready=0 for 5 cycles with 3 sets offered -> exactly 2 accepted, in_ready=0 thereafter, prod stable; release -> both delivered in order, then third accepted.
REQ-033 Assert rst_n low asynchronously with pipeline full -> out_valid, prod, op_count read 0 before next clk edge; no stale result after release.
REQ-034 Preload op_count by 65535 deliveries -> one more delivery wraps op_count to 0.
